// File: rtl/wiener_pkg.sv
// Shared FSM state type and AXI-style burst constants for the Wiener-filter
// output writer.
package wiener_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_ISSUE,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } wr_state_e;

  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [2:0] SIZE_4B    = 3'd2;

endpackage

// File: rtl/wiener_write_fifo.sv
// First-word fall-through pixel FIFO. A push into a full FIFO is kept only
// if a pop frees a slot in the same cycle; otherwise drop_o flags the loss.
module wiener_write_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [DATA_WIDTH-1:0]        push_data_i,
  input  logic                         pop_i,
  output logic [DATA_WIDTH-1:0]        head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  full, push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full || pop_ok);
  assign drop_o  = push_i && !flush_i && full && !pop_ok;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/memory_writer_wiener.sv
// Writes filtered pixels, arriving in block raster order, to memory as one
// BLOCK_SIZE-beat burst per block line.
module memory_writer_wiener
  import wiener_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           frame_height,
  input  logic [15:0]           frame_width,
  input  logic [ADDR_WIDTH-1:0] base_addr_out,
  input  logic                  start_of_frame,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  output logic                  start_write,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_len,
  output logic [2:0]            write_size,
  output logic [1:0]            write_burst,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  frame_written,
  output logic                  overflow
);

  localparam int DEPTH = 2 * BLOCK_SIZE;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [15:0]   BS16      = 16'(BLOCK_SIZE);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_SIZE - 1);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, write_addr_q, write_addr_d;
  logic [15:0]           line_q, line_d, block_col_q, block_col_d, block_row_q, block_row_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  overflow_q, overflow_d;
  logic                  fifo_flush, fifo_pop, fifo_empty, fifo_drop;
  logic [CW-1:0]         fifo_count;
  logic [15:0]           row_px, col_px, row_line;
  logic                  last_line, last_col, last_row;

  wiener_write_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (fifo_flush),
    .push_i      (pixel_valid),
    .push_data_i (pixel_in),
    .pop_i       (fifo_pop),
    .head_o      (wdata),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  assign row_px    = block_row_q * BS16;
  assign col_px    = block_col_q * BS16;
  assign row_line  = row_px + line_q;
  assign last_line = (line_q == BS16 - 16'd1);
  assign last_col  = ((col_px + BS16) == frame_width);
  assign last_row  = ((row_px + BS16) == frame_height);

  // Valid/ready: a beat transfers on any cycle with wvalid && wready; wvalid
  // never waits for wready, and wdata/wlast hold until the beat transfers.
  assign wvalid        = (state_q == ST_DATA) && !fifo_empty;
  assign fifo_pop      = wvalid && wready;
  assign wlast         = wvalid && (beat_q == LAST_BEAT);
  assign start_write   = (state_q == ST_ISSUE);
  assign frame_written = (state_q == ST_DONE);
  assign write_addr    = write_addr_q;
  assign write_len     = (state_q == ST_IDLE) ? 32'd0 : 32'(BLOCK_SIZE);
  assign write_size    = SIZE_4B;
  assign write_burst   = (state_q == ST_IDLE) ? 2'd0 : BURST_INCR;
  assign overflow      = overflow_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    write_addr_d = write_addr_q;
    line_d       = line_q;
    block_col_d  = block_col_q;
    block_row_d  = block_row_q;
    beat_d       = beat_q;
    fifo_flush   = 1'b0;
    overflow_d   = overflow_q | fifo_drop;
    case (state_q)
      ST_IDLE: begin
        if (start_of_frame) begin
          state_d     = ST_WAIT_LINE;
          base_d      = base_addr_out;
          line_d      = '0;
          block_col_d = '0;
          block_row_d = '0;
          fifo_flush  = 1'b1;
          overflow_d  = 1'b0;
        end
      end
      ST_WAIT_LINE: begin
        // Address is captured here so it stays fixed for the whole burst.
        if (fifo_count >= CW'(BLOCK_SIZE)) begin
          state_d      = ST_ISSUE;
          beat_d       = '0;
          write_addr_d = base_q + ADDR_WIDTH'(row_line) * ADDR_WIDTH'(frame_width)
                       + ADDR_WIDTH'(col_px);
        end
      end
      ST_ISSUE: state_d = ST_DATA;
      ST_DATA: begin
        if (fifo_pop) begin
          beat_d = beat_q + BW'(1);
          if (wlast) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bvalid) begin
          if (last_line) begin
            line_d = '0;
            if (last_col) begin
              block_col_d = '0;
              block_row_d = block_row_q + 16'd1;
            end else begin
              block_col_d = block_col_q + 16'd1;
            end
          end else begin
            line_d = line_q + 16'd1;
          end
          state_d = (last_line && last_col && last_row) ? ST_DONE : ST_WAIT_LINE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      write_addr_q <= '0;
      line_q       <= '0;
      block_col_q  <= '0;
      block_row_q  <= '0;
      beat_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      write_addr_q <= write_addr_d;
      line_q       <= line_d;
      block_col_q  <= block_col_d;
      block_row_q  <= block_row_d;
      beat_q       <= beat_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_memory_writer_wiener.sv
// Bench for memory_writer_wiener: random pixels and handshakes checked against
// a queue model of pixel order, burst addresses and overflow.
module tb_memory_writer_wiener;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BS = 8;
  localparam int DEPTH = 2 * BS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   frame_height, frame_width;
  logic [AW-1:0] base_addr_out;
  logic          start_of_frame;
  logic [DW-1:0] pixel_in;
  logic          pixel_valid;
  logic          start_write;
  logic [AW-1:0] write_addr;
  logic [31:0]   write_len;
  logic [2:0]    write_size;
  logic [1:0]    write_burst;
  logic [DW-1:0] wdata;
  logic          wvalid, wready, wlast, bvalid, frame_written, overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_writer_wiener #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_height   (frame_height),
    .frame_width    (frame_width),
    .base_addr_out  (base_addr_out),
    .start_of_frame (start_of_frame),
    .pixel_in       (pixel_in),
    .pixel_valid    (pixel_valid),
    .start_write    (start_write),
    .write_addr     (write_addr),
    .write_len      (write_len),
    .write_size     (write_size),
    .write_burst    (write_burst),
    .wdata          (wdata),
    .wvalid         (wvalid),
    .wready         (wready),
    .wlast          (wlast),
    .bvalid         (bvalid),
    .frame_written  (frame_written),
    .overflow       (overflow)
  );

  // Reference model: pixels accepted but not yet written, and addresses of
  // bursts still to come in the current frame.
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] obs_addr[$];
  bit active, exp_ovf, frame_done, resp_pending, fw_expect, spurious_en, wr_phase;
  int resp_cnt, bdelay, beat_idx, beats_total, pix_left, fw_count, pv_mode, wr_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_addr_q.delete();
    active = 0; exp_ovf = 0; resp_pending = 0; fw_expect = 0; beat_idx = 0;
  endtask

  task automatic arm_frame();
    exp_q.delete();
    exp_addr_q.delete();
    obs_addr.delete();
    for (int r = 0; r < int'(frame_height) / BS; r++)
      for (int c = 0; c < int'(frame_width) / BS; c++)
        for (int l = 0; l < BS; l++)
          exp_addr_q.push_back(base_addr_out + AW'((r * BS + l) * int'(frame_width) + c * BS));
    active = 1; exp_ovf = 0; frame_done = 0; fw_expect = 0;
    pix_left = int'(frame_width) * int'(frame_height);
    beat_idx = 0; beats_total = 0; fw_count = 0;
  endtask

  // One clock cycle: drive auto inputs, check outputs, advance the model.
  task automatic tick();
    bit pop, drop, sof_ok;
    int sz;
    logic [DW-1:0] exp_v;
    if (pv_mode != 0)
      pixel_valid = !start_of_frame && (pv_mode == 2 ||
                    (pix_left > 0 && exp_q.size() < 12 && $urandom_range(0, 3) != 0));
    if (pixel_valid) pixel_in = $urandom();
    case (wr_mode)
      1: wready = 1'b1;
      2: begin wready = wr_phase; wr_phase = !wr_phase; end
      3: wready = ($urandom_range(0, 1) == 1);
      default: ;
    endcase
    bvalid = (resp_pending && resp_cnt == 0) ||
             (spurious_en && !resp_pending && $urandom_range(0, 7) == 0);
    #1;
    if (rst_n) begin
      sz     = exp_q.size();
      pop    = wvalid && wready;
      sof_ok = start_of_frame && !active;
      chk("frame_written", frame_written, fw_expect);
      chk("overflow", overflow, exp_ovf);
      if (fw_expect) begin
        fw_expect = 0; active = 0;
      end
      if (frame_written) begin
        frame_done = 1; fw_count++;
      end
      if (start_write) begin
        chk("start_write_allowed", start_write, exp_addr_q.size() != 0);
        chk("write_len", write_len, BS);
        chk("write_burst", write_burst, 2'd1);
        chk("write_size", write_size, 3'd2);
        if (exp_addr_q.size() != 0) chk("write_addr", write_addr, exp_addr_q.pop_front());
        obs_addr.push_back(write_addr);
        beat_idx = 0;
      end
      if (resp_pending) begin
        if (resp_cnt == 0) begin
          resp_pending = 0;
          if (active && exp_addr_q.size() == 0) fw_expect = 1;
        end else begin
          resp_cnt--;
        end
      end
      if (wvalid) chk("wvalid_with_data", wvalid, sz != 0);
      if (pop) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk("wdata", wdata, exp_v);
        chk("wlast", wlast, beat_idx == BS - 1);
        if (beat_idx == BS - 1) begin
          resp_pending = 1; resp_cnt = bdelay;
        end
        beat_idx++; beats_total++;
      end
      drop = pixel_valid && sz == DEPTH && !pop;
      if (sof_ok) arm_frame();
      else if (pixel_valid) begin
        if (drop) exp_ovf = 1;
        else begin
          exp_q.push_back(pixel_in); pix_left--;
        end
      end
    end
    @(posedge clk);
    if (!rst_n) reset_model();
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [15:0] h, input logic [15:0] w, input logic [AW-1:0] base);
    frame_height = h; frame_width = w; base_addr_out = base;
    start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int budget);
    int n = 0;
    while (!frame_done && n < budget) begin
      tick(); n++;
    end
    chk({tag, "_done_in_budget"}, frame_done, 1'b1);
  endtask

  task automatic end_checks(input string tag, input int nbursts);
    chk({tag, "_bursts"}, obs_addr.size(), nbursts);
    chk({tag, "_beats"}, beats_total, nbursts * BS);
    chk({tag, "_written_pulses"}, fw_count, 1);
  endtask

  task automatic run_until(input int bursts, input int beat, input int budget);
    int n = 0;
    while (!(obs_addr.size() == bursts && beat_idx == beat) && n < budget) begin
      tick(); n++;
    end
    chk("reached_mid_burst", obs_addr.size(), bursts);
  endtask

  initial begin
    rst_n = 1'b0; frame_height = 16; frame_width = 16; base_addr_out = '0;
    start_of_frame = 1'b0; pixel_in = '0; pixel_valid = 1'b0; wready = 1'b0; bvalid = 1'b0;
    pv_mode = 0; wr_mode = 0; bdelay = 1; spurious_en = 0; wr_phase = 1;
    reset_model(); frame_done = 0; beats_total = 0; fw_count = 0; pix_left = 0;
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_start_write", start_write, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_frame_written", frame_written, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_write_addr", write_addr, '0);
    chk("rst_write_len", write_len, '0);
    chk("rst_write_burst", write_burst, 2'd0);

    // Pixels before any start_of_frame must not start a burst and get flushed.
    pixel_valid = 1'b1;
    repeat (10) tick();
    pixel_valid = 1'b0;

    // 16x16 frame, wready always high.
    pv_mode = 1; wr_mode = 1; bdelay = 1;
    start_frame(16, 16, 32'h1000);
    run_frame("f1", 3000);
    end_checks("f1", 32);
    chk("f1_addr0", obs_addr[0], 32'h1000);
    chk("f1_addr1", obs_addr[1], 32'h1010);
    chk("f1_addr7", obs_addr[7], 32'h1070);
    chk("f1_addr8", obs_addr[8], 32'h1008);
    chk("f1_addr16", obs_addr[16], 32'h1080);

    // 32x24 frame near the top of memory, wready toggling, stray bvalids.
    wr_mode = 2; spurious_en = 1; bdelay = $urandom_range(0, 3);
    start_frame(24, 32, 32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
    run_frame("f2", 8000);
    end_checks("f2", 96);

    // Constant pixel stream with slow responses forces drops.
    spurious_en = 0; wr_mode = 1; pv_mode = 2; bdelay = 20;
    start_frame(16, 16, 32'h4000);
    run_frame("f3", 4000);
    end_checks("f3", 32);
    chk("f3_overflow_set", overflow, 1'b1);

    // Push and pop together at full depth, then a push with no pop.
    pv_mode = 0; pixel_valid = 1'b0; wr_mode = 0; wready = 1'b0; bdelay = 2;
    start_frame(16, 16, 32'h2000);
    chk("f4_overflow_cleared", overflow, 1'b0);
    pixel_valid = 1'b1;
    repeat (DEPTH) tick();
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("f4_no_drop_at_full", overflow, 1'b0);
    tick();
    pixel_valid = 1'b0;
    chk("f4_drop_when_full", overflow, 1'b1);
    pv_mode = 1; wr_mode = 3;
    run_frame("f4", 4000);
    end_checks("f4", 32);

    // start_of_frame during DATA is ignored.
    bdelay = 3;
    start_frame(16, 16, 32'h5000);
    run_until(3, 2, 2000);
    base_addr_out = 32'hDEAD_0000; start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
    run_frame("f5", 4000);
    end_checks("f5", 32);
    chk("f5_addr3", obs_addr[3], 32'h5030);
    chk("f5_addr8", obs_addr[8], 32'h5008);

    // Reset at beat 4 of a burst, then a fresh frame.
    wr_mode = 1;
    start_frame(16, 16, 32'h6000);
    run_until(2, 4, 2000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_write_len", write_len, '0);
    chk("mid_rst_write_addr", write_addr, '0);
    chk("mid_rst_start_write", start_write, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    pv_mode = 0; pixel_valid = 1'b0;
    repeat (5) tick();
    pv_mode = 1;
    start_frame(16, 16, 32'h6000);
    run_frame("f6", 3000);
    end_checks("f6", 32);
    chk("f6_first_addr", obs_addr[0], 32'h6000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
